riscv_multicycle_core: RTL
==========================

# riscv_multicycle_core

Parametrised multi-cycle RV64I-subset processor core: PC, register file, instruction memory and data memory in one block, sequenced by a fetch/decode/execute/memory/writeback state machine. Executes add, sub, and, or, addi, ld, sd, beq and ecall, one instruction at a time, over several cycles. Instruction memory is loaded through a write port while the core is in reset or halted. Debug ports read registers and data memory for the bench.

## Interface
- XLEN, 64: datapath and register width; allowed values are 32 and 64.
- IMEM_DEPTH, 1024: instruction memory words (32-bit); power of two.
- DMEM_DEPTH, 1024: data memory words (XLEN-bit); power of two.
- RESET_PC, 0: PC value after reset.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- imem_we  in  1  instruction memory write enable.
- imem_waddr  in  $clog2(IMEM_DEPTH)  word index to write.
- imem_wdata  in  32  instruction word.
- dbg_reg_addr  in  5  register to observe.
- dbg_reg_data  out  XLEN  combinational read of register dbg_reg_addr; x0 reads 0.
- dbg_mem_addr  in  $clog2(DMEM_DEPTH)  data word index to observe.
- dbg_mem_data  out  XLEN  combinational read of data memory.
- pc  out  XLEN  current PC.
- halted  out  1  core stopped by ecall or illegal instruction.
- illegal  out  1  stop cause was an unsupported encoding.
- retired  out  32  count of completed instructions, wraps at 2^32.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: IR <= imem[pc[..:2] mod IMEM_DEPTH]; go to DECODE.
- DECODE: latch rs1/rs2 values and the immediate (I, S or B format, sign-extended to XLEN). Then:
  - ecall (opcode 1110011): go to HALT.
  - any encoding outside the supported set: set illegal=1 and go to HALT.
  - otherwise go to EXEC.
- EXEC:
  - R-type (0110011; funct7/funct3 select add/sub/and/or): go to WB.
  - addi (0010011, funct3 000): go to WB.
  - ld (0000011, funct3 011): address = rs1+imm; go to MEM.
  - sd (0100011, funct3 011): address = rs1+imm; go to MEM.
  - beq (1100011, funct3 000): pc <= (rs1==rs2) ? pc+imm : pc+4; retire; go to FETCH.
- MEM:
  - ld: MDR <= dmem[addr >> log2(XLEN/8) mod DMEM_DEPTH]; go to WB.
  - sd: write rs2 to that word; pc <= pc+4; retire; go to FETCH.
- WB: rd <= ALU result (or MDR for ld); pc <= pc+4; retire; go to FETCH.
- HALT: absorbing state; only reset leaves it.
- x0 writes are discarded. All arithmetic is modulo 2^XLEN, and the PC wraps the same way. Low address bits below the word size are ignored (no misalignment trap).
- imem writes are accepted only while reset=1 or halted=1; otherwise ignored.
- Data memory is not reset. The register file is cleared to 0 by reset.

## Timing
- Reset values:
  - pc=RESET_PC, halted=0, illegal=0, retired=0, all registers 0, state=FETCH.
  - The first FETCH occurs on the first edge after reset deasserts.
- Latency in cycles from entering FETCH until the next FETCH:
  - R-type and addi: 4.
  - ld: 5.
  - sd: 4.
  - beq: 3.
- ecall: FETCH then DECODE; halted=1 from the next cycle on. retired does not count ecall or an illegal instruction.
- retired and pc update on the same edge as the state returns to FETCH.
- dbg_reg_data reflects a WB write from the cycle after that edge.
- Reset asserted in any state, including mid-instruction, wins on that edge. A partial sd does not write memory unless the MEM edge has already occurred.
- When imem_we coincides with FETCH of the same address while halted, the fetch is moot; during reset the write lands and fetch is suppressed.

## Test plan
- ALU sequence: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; and x5,x1,x2; or x6,x1,x2; ecall -> x3=2, x4=8, x5=5, x6=-3 (all ones except bit1); retired=6; halted=1 after 26 cycles.
- Memory round trip: addi x1,x0,0x18; addi x2,x0,0x7F; sd x2,8(x1); ld x3,8(x1); ecall -> dbg_mem_addr=4 reads 0x7F; x3=0x7F; retired=4.
- Branch loop: x1=3; loop body addi x1,x1,-1; beq x1,x0,exit; beq x0,x0,loop -> exits with x1=0. Taken and not-taken beq each take exactly 3 cycles.
- x0 and wrap: addi x0,x0,9 -> x0 reads 0. addi x1,x0,-1 then addi x1,x1,1 -> x1=0. The same program at XLEN=32 gives the same results.
- Illegal stop: word 0xFFFFFFFF at pc 0 -> illegal=1, halted=1, retired=0, pc=0. An imem write while halted is accepted; reset then reruns the new program.
- Reset mid-instruction: assert reset during an ld's MEM cycle -> next cycle pc=RESET_PC, registers 0, retired=0, destination register unwritten.

Source files
------------

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: multi-cycle RV64I-subset core (add/sub/and/or/addi/ld/sd/beq/ecall)
module riscv_multicycle_core #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_reg_addr,
  output logic [XLEN-1:0]               dbg_reg_data,
  input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_mem_addr,
  output logic [XLEN-1:0]               dbg_mem_data,
  output logic [XLEN-1:0]               pc,
  output logic                          halted,
  output logic                          illegal,
  output logic [31:0]                   retired
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam int SH = $clog2(XLEN / 8);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic [31:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] a, b, imm, imm_d, alu, res, mdr, pc_n;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_r, is_addi, is_ld, is_sd, is_beq, is_ecall, legal, retire;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign is_r = op == 7'b0110011 && ((f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110))
                                     || (f7 == 7'h20 && f3 == 3'b000));
  assign is_addi = op == 7'b0010011 && f3 == 3'b000;
  assign is_ld = op == 7'b0000011 && f3 == 3'b011;
  assign is_sd = op == 7'b0100011 && f3 == 3'b011;
  assign is_beq = op == 7'b1100011 && f3 == 3'b000;
  assign is_ecall = op == 7'b1110011;
  assign legal = is_r || is_addi || is_ld || is_sd || is_beq;
  assign imm_d = is_sd  ? {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]} :
                 is_beq ? {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                          {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign alu = !is_r ? a + imm : f3 == 3'b111 ? a & b : f3 == 3'b110 ? a | b : f7[5] ? a - b : a + b;
  assign pc_n = (state == EXEC && a == b) ? pc + imm : pc + XLEN'(4);
  assign retire = state == WB || (state == EXEC && is_beq) || (state == MEM && is_sd);
  assign halted = state == HALT;
  assign dbg_reg_data = dbg_reg_addr == 5'd0 ? '0 : regs[dbg_reg_addr];
  assign dbg_mem_data = dmem[dbg_mem_addr];
  always_ff @(posedge clk)
    state <= reset ? FETCH : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:   state_n = DECODE;
      DECODE:  state_n = (is_ecall || !legal) ? HALT : EXEC;
      EXEC:    state_n = is_beq ? FETCH : (is_ld || is_sd) ? MEM : WB;
      MEM:     state_n = is_ld ? WB : FETCH;
      WB:      state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state == FETCH) ir <= imem[pc[IW+1:2]];
      if (state == DECODE) begin
        a <= ir[19:15] == 5'd0 ? '0 : regs[ir[19:15]];
        b <= ir[24:20] == 5'd0 ? '0 : regs[ir[24:20]];
        imm <= imm_d;
        illegal <= !is_ecall && !legal;
      end
      if (state == EXEC) res <= alu;
      if (state == MEM && is_ld) mdr <= dmem[res[SH+DW-1:SH]];
      if (retire) begin
        pc <= pc_n;
        retired <= retired + 32'd1;
      end
    end
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (state == WB && ir[11:7] != 5'd0)
      regs[ir[11:7]] <= is_ld ? mdr : res;
  // A pending store is dropped if reset lands on its MEM edge.
  always_ff @(posedge clk)
    if (!reset && state == MEM && is_sd) dmem[res[SH+DW-1:SH]] <= b;
  always_ff @(posedge clk)
    if (imem_we && (reset || state == HALT)) imem[imem_waddr] <= imem_wdata;
endmodule
